// File: rtl/pwm_decoder.sv
// Recovers the UDW-bit duty code of a PWM_FSM line by timing high/period on CE ticks.
// DUTY/VALID/ERR land one CLK after the deciding tick (2-CLK sync ahead); no backpressure, strobes are one-shot.
module pwm_decoder #(
    parameter int UDW = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           CE,
    input  logic           PWM_IN,
    output logic [UDW-1:0] DUTY,
    output logic           VALID,
    output logic           ERR,
    output logic           STUCK
);
    localparam int CW = UDW + 1;
    localparam logic [CW-1:0] PERIOD = {1'b1, {UDW{1'b0}}};
    localparam logic [CW-1:0] ONE    = {{UDW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] CMAX   = {CW{1'b1}};

    typedef enum logic {
        ACQ  = 1'b0,
        MEAS = 1'b1
    } state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (x == CMAX) ? x : x + ONE;
    endfunction

    logic [1:0]     sync_q;
    logic           sp_q, sp_d;
    state_t         state_q, state_d;
    logic [CW-1:0]  pcnt_q, pcnt_d;
    logic [CW-1:0]  hcnt_q, hcnt_d;
    logic [CW-1:0]  run_q, run_d;
    logic [UDW-1:0] duty_q, duty_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic           stuck_q, stuck_d;

    logic s;
    logic rise;
    logic fall;

    assign s    = sync_q[1];
    assign rise = s & ~sp_q;
    assign fall = ~s & sp_q;

    always_comb begin
        sp_d    = sp_q;
        state_d = state_q;
        pcnt_d  = pcnt_q;
        hcnt_d  = hcnt_q;
        run_d   = run_q;
        duty_d  = duty_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        stuck_d = stuck_q;

        if (CE) begin
            sp_d = s;
            if (rise) begin
                // The first rise out of ACQ only opens a period; it has nothing to judge yet.
                if (state_q == MEAS) begin
                    if (pcnt_q == PERIOD) begin
                        duty_d  = hcnt_q[UDW-1:0];
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                pcnt_d  = ONE;
                hcnt_d  = ONE;
                run_d   = ONE;
                state_d = MEAS;
            end else begin
                pcnt_d = sat_inc(pcnt_q);
                if (s) begin
                    hcnt_d = sat_inc(hcnt_q);
                end
                if (fall) begin
                    run_d   = ONE;
                    stuck_d = 1'b0;
                end else begin
                    run_d = sat_inc(run_q);
                end

                if (run_d == PERIOD) begin
                    if (!s) begin
                        // A full period of low is the legal encoding of code 0.
                        duty_d  = '0;
                        valid_d = 1'b1;
                        run_d   = '0;
                    end else begin
                        stuck_d = 1'b1;
                    end
                    state_d = ACQ;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q  <= 2'b00;
            sp_q    <= 1'b0;
            state_q <= ACQ;
            pcnt_q  <= '0;
            hcnt_q  <= '0;
            run_q   <= '0;
            duty_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], PWM_IN};
            sp_q    <= sp_d;
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            hcnt_q  <= hcnt_d;
            run_q   <= run_d;
            duty_q  <= duty_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            stuck_q <= stuck_d;
        end
    end

    assign DUTY  = duty_q;
    assign VALID = valid_q;
    assign ERR   = err_q;
    assign STUCK = stuck_q;

endmodule

// File: doc/pwm_decoder.md
# pwm_decoder

Receiving end of the on-board PWM link: it recovers the UDW-bit duty code that a `PWM_FSM` instance with the same `UDW` is sending on one wire. It samples an asynchronous PWM input on `CE` ticks and measures high time and period between rising edges. It reports the code with a one-cycle `VALID` strobe and flags malformed periods and stuck-high lines. It sits beside the LED/matrix datapath and lets a board read back or loop-test any `PWM_FSM` output.

## Interface
- `UDW`, 4, duty code width; the nominal PWM period is P = 2^UDW `CE` ticks.
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  reset, asynchronous, active-low; all state is cleared while low.
- `CE`  in  1  sample tick; all measurement happens only on `CLK` edges with `CE`=1.
- `PWM_IN`  in  1  asynchronous PWM line.
- `DUTY`  out  UDW  last decoded duty code, held between updates.
- `VALID`  out  1  one-`CLK` strobe: `DUTY` was just updated.
- `ERR`  out  1  one-`CLK` strobe: a completed period had length ≠ P; `DUTY` is not updated.
- `STUCK`  out  1  level: line has been high for ≥ P consecutive ticks.

## Operation
- Synchroniser: two flops on `CLK`, not gated by `CE`, reset to 0. Its output is `S`.
- Prev flop `SP` is updated to `S` on each `CE` tick. A tick is a rise when `S`=1 and `SP`=0, and a fall when `S`=0 and `SP`=1.
- Counters are UDW+1 bits and saturate at 2^(UDW+1)−1:
  - `PCNT` counts ticks since the last rise.
  - `HCNT` counts high ticks since the last rise.
  - `RUN` counts consecutive ticks at the current level.
- State machine: ACQ (reset state; no valid period start yet) and MEAS.
- Rise tick in ACQ: set `PCNT`=1, `HCNT`=1 and `RUN`=1, then go to MEAS. No output.
- Rise tick in MEAS:
  - If `PCNT`=P: set `DUTY` to `HCNT[UDW-1:0]` and pulse `VALID`.
  - Otherwise: pulse `ERR` and leave `DUTY` unchanged.
  - In both cases, then set `PCNT`=1, `HCNT`=1 and `RUN`=1, and stay in MEAS.
- Non-rise tick: increment `PCNT`. Increment `HCNT` if `S`=1. Increment `RUN` if the level is unchanged; set `RUN`=1 if the level changed.
- Low timeout (any state): if `RUN` reaches P with `S`=0, set `DUTY`=0, pulse `VALID`, set `RUN`=0 and go to ACQ. This repeats every P low ticks. Code 0 is the only legal constant-low input; a legal code ≥1 has a longest low run of P−1.
- Stuck high: if `RUN` reaches P with `S`=1, set `STUCK`=1 and go to ACQ, with `DUTY` unchanged. `STUCK` clears on the next fall tick. The `RUN` counter saturates and does not wrap.
- A rise and a timeout cannot coincide, because a rise always sets `RUN`=1.
- Reset (`RST`=0, any time, including mid-period):
  - `DUTY`=0, `VALID`=0, `ERR`=0, `STUCK`=0.
  - State = ACQ; counters, synchroniser and `SP` = 0.
  - The first rise after reset produces no strobe.
- `CE`=0 cycles freeze the state machine and counters; only the synchroniser advances.

## Timing
- Input-to-sample latency is 2 `CLK` cycles through the synchroniser.
- `VALID`, `ERR` and `DUTY` are registered. They change on the `CLK` edge of the rise tick (or timeout tick) and are visible in the following cycle.
- `VALID`/`ERR` are high for exactly 1 `CLK` cycle, regardless of `CE` spacing. `VALID` and `ERR` are never high together.
- The first `VALID` arrives at the second rise after reset, about one period plus 2 clocks after the first rise reaches the pin.
- Steady state: one `VALID` per period, at each rise.

## Test plan
- UDW=4, `CE`=1 every clock, line repeating 5 high / 11 low: no strobe on the first rise. Every later rise gives `VALID` with `DUTY`=5; `ERR`=0 and `STUCK`=0 throughout.
- Same line with `CE` on every 4th clock, pattern 15 high / 1 low (in ticks): `DUTY`=15, with `VALID` once per 64 clocks.
- Constant low from reset: `VALID` with `DUTY`=0 at tick 16, then every 16 ticks after that; `ERR` never asserted.
- Constant high from reset: `STUCK`=1 after 16 high ticks, no `VALID`. Then drive 3 high / 13 low: `STUCK` clears at the first fall, and `DUTY`=3 from the second rise onward.
- Pattern 3 high / 9 low (12-tick period) after a valid `DUTY`=5 phase: `ERR` pulses at each rise, `DUTY` stays 5, `VALID`=0.
- Assert `RST` low mid-period while `DUTY`=5: all outputs read 0 immediately. After release, the first rise gives no strobe and the second gives `VALID`.
